dcache_wb: RTL and testbench

// Data-side responder on the datapath/cache interface. Services dmemREN/dmemWEN from the pipeline's MEM stage

---
 rtl/dcache_wb_pkg.sv | 47 ++++
 rtl/dcache_frame_array.sv | 31 +++
 rtl/dcache_wb.sv | 220 ++++++++++++++++++++++
 tb/tb_dcache_wb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_wb_pkg.sv
// Shared types for the write-back data cache: address split,
// frame layout and controller states.
package dcache_wb_pkg;

    typedef logic [31:0] word_t;

    localparam int DC_SETS  = 16;
    localparam int DC_IDX_W = $clog2(DC_SETS);
    localparam int DC_TAG_W = 32 - DC_IDX_W - 3;
    // Widest tag any legal SETS can need; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef struct packed {
        logic [DC_TAG_W-1:0] tag;
        logic [DC_IDX_W-1:0] idx;
        logic                blkoff;
        logic [1:0]          bytoff;
    } dcachef_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
        word_t [1:0]          data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FL_CHK,
        FL_WB0,
        FL_WB1,
        CNT_WR,
        DONE
    } dc_state_t;

    function automatic word_t word_addr(
        input logic [TAG_MAX_W-1:0] blk,
        input logic                 b
    );
        return {blk, b, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Frame storage for the data cache: one synchronous write port,
// asynchronous read by index, synchronous clear-all on reset.
module dcache_frame_array
    import dcache_wb_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(SETS)-1:0]   widx,
    input  dcache_frame_t             wdata,
    input  logic [$clog2(SETS)-1:0]   ridx,
    output dcache_frame_t             rdata
);

    dcache_frame_t frames [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else if (we) begin
            frames[widx] <= wdata;
        end
    end

    assign rdata = frames[ridx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with 2-word
// blocks; flushes dirty frames and reports the hit count on halt.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int          SETS         = 16,
    parameter logic [31:0] HIT_CNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = TAG_MAX_W - IDX_W;

    dc_state_t state, nstate;

    logic [IDX_W-1:0]     fl_idx;
    logic                 fl_inc;
    logic                 fl_clr;
    logic [31:0]          hit_count;
    logic                 miss_pending;

    dcachef_t             req;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_MAX_W-1:0] req_tag;
    logic [TAG_MAX_W-1:0] req_blk;
    logic [TAG_MAX_W-1:0] vic_blk;
    logic                 req_any;
    logic                 hit;
    logic                 miss;
    logic                 fl_last;
    logic                 flushing;

    logic [IDX_W-1:0]     rd_idx;
    dcache_frame_t        rd_frame;
    dcache_frame_t        wframe;
    logic                 we;

    assign req     = dmemaddr;
    assign req_idx = dmemaddr[IDX_W+2:3];
    assign req_tag = {{IDX_W{1'b0}}, dmemaddr[31:IDX_W+3]};
    assign req_blk = dmemaddr[31:3];
    assign req_any = dmemREN | dmemWEN;

    assign flushing = (state == FL_CHK) || (state == FL_WB0)
                   || (state == FL_WB1);
    assign rd_idx   = flushing ? fl_idx : req_idx;
    assign vic_blk  = {rd_frame.tag[TAG_W-1:0], rd_idx};
    assign fl_last  = (fl_idx == IDX_W'(SETS - 1));

    assign hit  = rd_frame.valid && (rd_frame.tag == req_tag);
    assign dhit = (state == IDLE) && !halt && req_any && hit;
    assign miss = (state == IDLE) && !halt && req_any && !hit;

    assign dmemload = dhit ? rd_frame.data[req.blkoff] : '0;
    assign flushed  = (state == DONE);

    logic unused_ok;
    assign unused_ok = ^{req.tag, req.idx, req.bytoff,
                         rd_frame.tag[TAG_MAX_W-1:TAG_W]};

    dcache_frame_array #(
        .SETS (SETS)
    ) u_frames (
        .clk   (CLK),
        .rst   (RST),
        .we    (we),
        .widx  (rd_idx),
        .wdata (wframe),
        .ridx  (rd_idx),
        .rdata (rd_frame)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            fl_idx       <= '0;
            hit_count    <= '0;
            miss_pending <= 1'b0;
        end else begin
            state <= nstate;
            if (fl_clr) begin
                fl_idx <= '0;
            end else if (fl_inc) begin
                fl_idx <= fl_idx + 1'b1;
            end
            // The hit that retires a miss is not counted.
            if (dhit) begin
                if (!miss_pending) begin
                    hit_count <= hit_count + 32'd1;
                end
                miss_pending <= 1'b0;
            end else if (miss) begin
                miss_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        nstate = state;
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        we     = 1'b0;
        wframe = rd_frame;
        fl_inc = 1'b0;
        fl_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (halt) begin
                    nstate = FL_CHK;
                end else if (req_any && hit) begin
                    if (dmemWEN) begin
                        we                       = 1'b1;
                        wframe.data[req.blkoff]  = dmemstore;
                        wframe.dirty             = 1'b1;
                    end
                end else if (req_any) begin
                    nstate = (rd_frame.valid && rd_frame.dirty) ? WB0 : LD0;
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = word_addr(vic_blk, 1'b0);
                dstore = rd_frame.data[0];
                if (!dwait) nstate = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = word_addr(vic_blk, 1'b1);
                dstore = rd_frame.data[1];
                if (!dwait) nstate = LD0;
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = word_addr(req_blk, 1'b0);
                if (!dwait) begin
                    we             = 1'b1;
                    wframe.valid   = 1'b0;
                    wframe.data[0] = dload;
                    nstate         = LD1;
                end
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = word_addr(req_blk, 1'b1);
                if (!dwait) begin
                    we             = 1'b1;
                    wframe.data[1] = dload;
                    wframe.tag     = req_tag;
                    wframe.valid   = 1'b1;
                    wframe.dirty   = 1'b0;
                    nstate         = IDLE;
                end
            end
            FL_CHK: begin
                if (rd_frame.valid && rd_frame.dirty) begin
                    nstate = FL_WB0;
                end else if (fl_last) begin
                    nstate = CNT_WR;
                end else begin
                    fl_inc = 1'b1;
                end
            end
            FL_WB0: begin
                dWEN   = 1'b1;
                daddr  = word_addr(vic_blk, 1'b0);
                dstore = rd_frame.data[0];
                if (!dwait) nstate = FL_WB1;
            end
            FL_WB1: begin
                dWEN   = 1'b1;
                daddr  = word_addr(vic_blk, 1'b1);
                dstore = rd_frame.data[1];
                if (!dwait) begin
                    we           = 1'b1;
                    wframe.dirty = 1'b0;
                    if (fl_last) begin
                        nstate = CNT_WR;
                    end else begin
                        fl_inc = 1'b1;
                        nstate = FL_CHK;
                    end
                end
            end
            CNT_WR: begin
                dWEN   = 1'b1;
                daddr  = HIT_CNT_ADDR;
                dstore = hit_count;
                if (!dwait) begin
                    fl_clr = 1'b1;
                    nstate = DONE;
                end
            end
            DONE: begin
                nstate = DONE;
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a behavioural word memory
// and a log of completed bus transfers.
module tb_dcache_wb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload = '0;
    logic        dwait = 1'b0;

    dcache_wb dut (
        .CLK       (CLK),
        .RST       (RST),
        .halt      (halt),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       log_q[$];
    logic [31:0] mem [logic [31:0]];
    int          npass = 0;
    int          ntot = 0;
    int          excl_viol = 0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : f(a);
    endfunction

    // Memory and transfer log, sampled just before each rising edge.
    always @(negedge CLK) begin
        #4;
        if (dREN && dWEN) excl_viol++;
        dload = dREN ? rdmem(daddr) : 32'h0;
        if (!RST && (dREN || dWEN) && !dwait) begin
            if (dWEN) mem[daddr] = dstore;
            log_q.push_back('{we: dWEN, a: daddr, d: dWEN ? dstore : dload});
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_xfer(input string tag, input int i, input bit we,
                            input logic [31:0] a, input logic [31:0] d);
        if (i < log_q.size()) begin
            check({tag, "_we"}, 32'(log_q[i].we), 32'(we));
            check({tag, "_addr"}, log_q[i].a, a);
            check({tag, "_data"}, log_q[i].d, d);
        end else begin
            check({tag, "_missing"}, 32'(log_q.size()), 32'(i + 1));
        end
    endtask

    task automatic access(input logic wen, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd);
        lat = 0;
        @(negedge CLK);
        dmemREN = !wen;
        dmemWEN = wen;
        dmemaddr = a;
        dmemstore = wd;
        #1;
        while (!dhit && lat < 50) begin
            @(negedge CLK);
            #1;
            lat++;
        end
        rd = dmemload;
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        dwait = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic [31:0] exp_a [7];
    logic [31:0] exp_d [7];
    bit          stable;

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_outs", {dhit, flushed, dREN, dWEN}, 32'h0);
        check("rst_daddr", daddr, 32'h0);
        check("rst_dload", dmemload, 32'h0);

        // Cold load, then neighbour word hit
        log_q.delete();
        access(1'b0, 32'h40, 32'h0, lat, rd);
        check("t1_lat", lat, 3);
        check("t1_load", rd, f(32'h40));
        check("t1_nxfer", log_q.size(), 2);
        chk_xfer("t1_ld0", 0, 1'b0, 32'h40, f(32'h40));
        chk_xfer("t1_ld1", 1, 1'b0, 32'h44, f(32'h44));
        access(1'b0, 32'h44, 32'h0, lat, rd);
        check("t1_hit_lat", lat, 0);
        check("t1_hit_load", rd, f(32'h44));

        // Dirty eviction
        access(1'b1, 32'h40, 32'hDEADBEEF, lat, rd);
        check("t2_st_lat", lat, 0);
        log_q.delete();
        access(1'b0, 32'h440, 32'h0, lat, rd);
        check("t2_lat", lat, 5);
        check("t2_load", rd, f(32'h440));
        check("t2_nxfer", log_q.size(), 4);
        chk_xfer("t2_wb0", 0, 1'b1, 32'h40, 32'hDEADBEEF);
        chk_xfer("t2_wb1", 1, 1'b1, 32'h44, f(32'h44));
        chk_xfer("t2_ld0", 2, 1'b0, 32'h440, f(32'h440));
        chk_xfer("t2_ld1", 3, 1'b0, 32'h444, f(32'h444));
        access(1'b0, 32'h40, 32'h0, lat, rd);
        check("t2_reload_lat", lat, 3);
        check("t2_reload", rd, 32'hDEADBEEF);

        // Memory stall during LD0
        dwait = 1'b1;
        @(negedge CLK);
        dmemREN = 1'b1;
        dmemaddr = 32'h80;
        #1;
        check("t3_miss_nohit", 32'(dhit), 0);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            if (!(dREN && !dWEN && daddr == 32'h80 && !dhit)) stable = 1'b0;
        end
        check("t3_stall_stable", 32'(stable), 1);
        dwait = 1'b0;
        lat = 0;
        while (!dhit && lat < 50) begin
            @(negedge CLK);
            #1;
            lat++;
        end
        check("t3_lat", lat, 2);
        check("t3_load", dmemload, f(32'h80));
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;

        // REN and WEN together on a hit: store wins
        @(negedge CLK);
        dmemREN = 1'b1;
        dmemWEN = 1'b1;
        dmemaddr = 32'h84;
        dmemstore = 32'h12345678;
        #1;
        check("t6_dhit", 32'(dhit), 1);
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        #1;
        check("t6_dhit_drop", 32'(dhit), 0);
        access(1'b0, 32'h84, 32'h0, lat, rd);
        check("t6_readback", rd, 32'h12345678);
        log_q.delete();
        access(1'b0, 32'h480, 32'h0, lat, rd);
        check("t6_evict_lat", lat, 5);
        chk_xfer("t6_wb1", 1, 1'b1, 32'h84, 32'h12345678);

        // Reset in the middle of WB1
        access(1'b1, 32'h40, 32'hCAFEF00D, lat, rd);
        check("t5_st_lat", lat, 0);
        @(negedge CLK);
        dmemREN = 1'b1;
        dmemaddr = 32'h440;
        @(negedge CLK);
        #1;
        check("t5_wb0", 32'(dWEN), 1);
        @(negedge CLK);
        dwait = 1'b1;
        #1;
        check("t5_wb1_addr", daddr, 32'h44);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("t5_rst_bus", {dREN, dWEN}, 32'h0);
        dmemREN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        dwait = 1'b0;
        log_q.delete();
        access(1'b0, 32'h40, 32'h0, lat, rd);
        check("t5_lat", lat, 3);
        check("t5_load", rd, 32'hCAFEF00D);
        check("t5_nxfer", log_q.size(), 2);
        chk_xfer("t5_ld0", 0, 1'b0, 32'h40, 32'hCAFEF00D);

        // Flush of dirty frames 1, 5, 15 after 7 counted hits
        do_reset();
        access(1'b1, 32'h08, 32'h11111111, lat, rd);
        access(1'b1, 32'h28, 32'h55555555, lat, rd);
        access(1'b1, 32'h78, 32'hFFFF0000, lat, rd);
        access(1'b0, 32'h08, 32'h0, lat, rd);
        access(1'b0, 32'h0C, 32'h0, lat, rd);
        access(1'b0, 32'h28, 32'h0, lat, rd);
        access(1'b0, 32'h2C, 32'h0, lat, rd);
        access(1'b0, 32'h78, 32'h0, lat, rd);
        access(1'b0, 32'h7C, 32'h0, lat, rd);
        access(1'b0, 32'h08, 32'h0, lat, rd);
        check("t4_last_hit", rd, 32'h11111111);
        log_q.delete();
        @(negedge CLK);
        halt = 1'b1;
        dmemREN = 1'b1;
        dmemaddr = 32'h08;
        #1;
        check("t4_halt_nohit", 32'(dhit), 0);
        lat = 0;
        while (!flushed && lat < 300) begin
            @(negedge CLK);
            #1;
            lat++;
        end
        check("t4_flushed", 32'(flushed), 1);
        exp_a = '{32'h08, 32'h0C, 32'h28, 32'h2C, 32'h78, 32'h7C, 32'h3100};
        exp_d = '{32'h11111111, f(32'h0C), 32'h55555555, f(32'h2C),
                  32'hFFFF0000, f(32'h7C), 32'd7};
        check("t4_nxfer", log_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk_xfer($sformatf("t4_x%0d", i), i, 1'b1, exp_a[i], exp_d[i]);
        end
        repeat (4) @(negedge CLK);
        #1;
        check("t4_done_outs", {flushed, dhit, dREN, dWEN}, 32'h8);
        check("t4_excl", excl_viol, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
